// File: rtl/i2c_bus_cond.sv
// I2C pad-input conditioning: synchronizes and glitch-filters SCL/SDA, derives
// SCL edges, START/STOP events, bus busy/free status and an SCL-low timeout.
module i2c_bus_cond #(
    parameter int FilterCycles = 4,
    parameter int TimeoutW     = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                scl_i,
    input  logic                sda_i,
    input  logic [TimeoutW-1:0] stretch_timeout_i,
    input  logic [TimeoutW-1:0] bus_free_i,
    output logic                scl_f_o,
    output logic                sda_f_o,
    output logic                scl_rise_o,
    output logic                scl_fall_o,
    output logic                start_det_o,
    output logic                stop_det_o,
    output logic                bus_busy_o,
    output logic                bus_free_o,
    output logic                scl_timeout_o
);

    localparam int FcW = (FilterCycles > 1) ? $clog2(FilterCycles + 1) : 1;
    // The filtered line flips on the cycle the run counter would reach FilterCycles.
    localparam logic [FcW-1:0] FcLast = FcW'(FilterCycles - 1);

    // Bit 0 carries SCL, bit 1 carries SDA throughout.
    logic [1:0]          r_sync1;
    logic [1:0]          r_sync2;
    logic [1:0]          r_filt;
    logic [1:0]          r_filt_d;
    logic [FcW-1:0]      r_fcnt [2];
    logic                r_busy;
    logic                r_bus_free;
    logic [TimeoutW-1:0] r_free_cnt;
    logic [TimeoutW-1:0] r_to_cnt;
    logic                r_to_fired;

    logic w_scl_f;
    logic w_scl_d;
    logic w_sda_f;
    logic w_sda_d;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_scl_steady_hi;
    logic w_start;
    logic w_stop;
    logic w_idle;
    logic w_to_run;
    logic w_to_hit;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1   <= 2'b11;
            r_sync2   <= 2'b11;
            r_filt    <= 2'b11;
            r_filt_d  <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_sync1  <= {sda_i, scl_i};
            r_sync2  <= r_sync1;
            r_filt_d <= r_filt;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_filt[i]) begin
                    r_fcnt[i] <= '0;
                end else if (r_fcnt[i] == FcLast) begin
                    r_filt[i] <= r_sync2[i];
                    r_fcnt[i] <= '0;
                end else begin
                    r_fcnt[i] <= r_fcnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_scl_f = r_filt[0];
    assign w_scl_d = r_filt_d[0];
    assign w_sda_f = r_filt[1];
    assign w_sda_d = r_filt_d[1];

    assign w_scl_rise      = w_scl_f & ~w_scl_d;
    assign w_scl_fall      = ~w_scl_f & w_scl_d;
    // START/STOP only count when SCL was high in both this and the previous cycle.
    assign w_scl_steady_hi = w_scl_f & w_scl_d;
    assign w_start         = w_scl_steady_hi & ~w_sda_f & w_sda_d;
    assign w_stop          = w_scl_steady_hi & w_sda_f & ~w_sda_d;

    assign w_idle   = ~r_busy & w_scl_f & w_sda_f;
    assign w_to_run = r_busy & ~w_scl_f;
    // Equality (not >=) so a threshold lowered mid-count never fires retroactively.
    assign w_to_hit = w_to_run && (stretch_timeout_i != '0) &&
                      (r_to_cnt == stretch_timeout_i) && !r_to_fired;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
        end else if (w_start) begin
            r_busy <= 1'b1;
        end else if (w_stop) begin
            r_busy <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_free_cnt <= '0;
            r_bus_free <= 1'b0;
        end else begin
            if (!w_idle) begin
                r_free_cnt <= '0;
            end else if (!(&r_free_cnt)) begin
                r_free_cnt <= r_free_cnt + 1'b1;
            end
            r_bus_free <= w_idle && (r_free_cnt >= bus_free_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_to_cnt   <= '0;
            r_to_fired <= 1'b0;
        end else if (!w_to_run) begin
            r_to_cnt   <= '0;
            r_to_fired <= 1'b0;
        end else begin
            if (!(&r_to_cnt)) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            r_to_fired <= r_to_fired | w_to_hit;
        end
    end

    assign scl_f_o       = w_scl_f;
    assign sda_f_o       = w_sda_f;
    assign bus_busy_o    = r_busy;
    assign bus_free_o    = r_bus_free;
    // Pulses are masked while reset is asserted so nothing leaks out mid-reset.
    assign scl_rise_o    = w_scl_rise & ~rst_i;
    assign scl_fall_o    = w_scl_fall & ~rst_i;
    assign start_det_o   = w_start & ~rst_i;
    assign stop_det_o    = w_stop & ~rst_i;
    assign scl_timeout_o = w_to_hit & ~rst_i;

endmodule
